pc_fetch_stage: RTL

//  IF-stage block that consumes the 28-bit shifted jump field from shifter2.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/pc_target_mux.sv | 45 ++++
 rtl/pc_fetch_stage.sv | 99 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage constants and types (BRANCH_DELAY_SLOT_EN aware users)
package mips_pkg;

   // PC loaded on reset and the bubble instruction word (sll $0,$0,0)
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      REDIRECT = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      SEL_PC4 = 2'd0,
      SEL_BR  = 2'd1,
      SEL_J   = 2'd2,
      SEL_JR  = 2'd3
   } pc_sel_t;

endpackage

// File: rtl/pc_target_mux.sv
// rtl/pc_target_mux.sv - redirect target formation and next-PC priority select
module pc_target_mux
   import mips_pkg::*;
(
   input  logic        allow_i,
   input  logic        ifid_valid_i,
   input  logic [31:0] seq_pc4_i,
   input  logic [31:0] ifid_pc4_i,
   input  logic [27:0] jaddr28_i,
   input  logic [31:0] branch_off_i,
   input  logic [31:0] jr_target_i,
   input  logic        jr_i,
   input  logic        jump_i,
   input  logic        branch_taken_i,
   output logic        redir_o,
   output logic [31:0] next_pc_o
);

   logic [31:0] j_tgt;
   logic [31:0] b_tgt;
   pc_sel_t     sel;

   // Targets are relative to the instruction sitting in ID; jr > jump > branch > pc4
   always_comb begin
      j_tgt   = {ifid_pc4_i[31:28], jaddr28_i};
      b_tgt   = ifid_pc4_i + branch_off_i;
      redir_o = allow_i & ifid_valid_i & (jr_i | jump_i | branch_taken_i);
      sel     = SEL_PC4;
      if (redir_o) begin
         if (jr_i)
            sel = SEL_JR;
         else if (jump_i)
            sel = SEL_J;
         else
            sel = SEL_BR;
      end
      case (sel)
         SEL_JR:  next_pc_o = jr_target_i;
         SEL_J:   next_pc_o = j_tgt;
         SEL_BR:  next_pc_o = b_tgt;
         default: next_pc_o = seq_pc4_i;
      endcase
   end

endmodule

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - IF stage: PC register, fetch FSM and IF/ID register (BRANCH_DELAY_SLOT_EN)
module pc_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        jump,
   input  logic [27:0] jaddr28,
   input  logic        branch_taken,
   input  logic [31:0] branch_off,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] ifid_pc4,
   output logic [31:0] ifid_instr,
   output logic        ifid_valid
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  ifid_pc4_q, ifid_pc4_d;
   logic [31:0]  ifid_instr_q, ifid_instr_d;
   logic         ifid_valid_q, ifid_valid_d;
   logic [31:0]  seq_pc4;
   logic [31:0]  next_pc;
   logic         redir;

   assign seq_pc4 = pc_q + 32'd4;

   pc_target_mux u_mux (
      .allow_i        (state_q == RUN),
      .ifid_valid_i   (ifid_valid_q),
      .seq_pc4_i      (seq_pc4),
      .ifid_pc4_i     (ifid_pc4_q),
      .jaddr28_i      (jaddr28),
      .branch_off_i   (branch_off),
      .jr_target_i    (jr_target),
      .jr_i           (jr),
      .jump_i         (jump),
      .branch_taken_i (branch_taken),
      .redir_o        (redir),
      .next_pc_o      (next_pc)
   );

   // Next-state: stall freezes everything; a redirect is only honoured in RUN
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      if (!stall) begin
         pc_d         = next_pc;
         ifid_pc4_d   = seq_pc4;
         ifid_instr_d = imem_rdata;
         ifid_valid_d = 1'b1;
         state_d      = RUN;
         if (redir) begin
            state_d = REDIRECT;
`ifdef BRANCH_DELAY_SLOT_EN
            // The instruction already fetched behind the jump executes as the slot
            ifid_valid_d = 1'b1;
`else
            ifid_pc4_d   = 32'd0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
`endif
         end
      end
   end

   // State registers with synchronous reset; reset also drops any pending redirect
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         ifid_pc4_q   <= 32'd0;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign pc_out     = pc_q;
   assign ifid_pc4   = ifid_pc4_q;
   assign ifid_instr = ifid_instr_q;
   assign ifid_valid = ifid_valid_q;

endmodule
